// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary-to-Gray stage between two requesters.
// One transaction in flight at a time: IDLE (grant) -> CONV (convert) -> RESP (hold result).
module gray_conv_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_bin,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_bin,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_gray,
   input  logic             rsp_ready,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [WIDTH-1:0] gray_q;
   logic             winner;

   // On a tie the requester not served last time wins; otherwise the lone requester.
   always_comb begin
      if (req0_valid && req1_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = req1_valid;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      op_d         = op_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp_valid    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Gated by rst so both readys read 0 while reset is held.
            req0_ready = rst && req0_valid && !winner;
            req1_ready = rst && req1_valid && winner;
            if (req0_ready || req1_ready) begin
               id_d    = winner;
               op_d    = winner ? req1_bin : req0_bin;
               state_d = StConv;
            end
         end
         StConv: begin
            state_d = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               last_grant_d = id_q;
               state_d      = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         op_q         <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         op_q         <= op_d;
      end
   end

   // Conversion register: free-running on op_q, so it stays stable while op_q is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gray_q <= '0;
      end else begin
         gray_q <= op_q ^ (op_q >> 1);
      end
   end

   assign busy     = (state_q != StIdle);
   assign rsp_id   = id_q;
   assign rsp_gray = gray_q;

endmodule
